// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired control unit for the DataPath.
// Sequences fetch (T0-T2) and execute (T3-T7) for ld, ldi, st, add, sub,
// addi, nop and halt, decoding the opcode in ir[31:27].
// Optional build macro CU_MEM_WAIT_EN adds the mem_rdy handshake. With it,
// T1, ld T6 and st T7 hold until memory is ready.
//
// state | meaning
// IDLE  | waiting for run, all outputs low
// T0    | PC to MAR, start PC increment
// T1    | PC <- PC+1, memory read into MDR
// T2    | MDR to IR
// T3    | first execute step, opcode decoded from ir and latched
// T4-T7 | remaining execute steps, driven by the latched opcode
// HALT  | parked with halted high until clear
module ctrl_sequencer #(
    parameter logic [4:0] OP_ADD   = 5'b00011,
    parameter logic [4:0] OP_SUB   = 5'b00100,
    parameter logic [4:0] OPC_LD   = 5'b00000,
    parameter logic [4:0] OPC_LDI  = 5'b00001,
    parameter logic [4:0] OPC_ST   = 5'b00010,
    parameter logic [4:0] OPC_ADD  = 5'b00011,
    parameter logic [4:0] OPC_SUB  = 5'b00100,
    parameter logic [4:0] OPC_ADDI = 5'b01100,
    parameter logic [4:0] OPC_NOP  = 5'b11010,
    parameter logic [4:0] OPC_HALT = 5'b11011
) (
    input  logic        clock,
    input  logic        clear,
`ifdef CU_MEM_WAIT_EN
    input  logic        mem_rdy,
`endif
    input  logic [31:0] ir,
    input  logic        run,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Read,
    output logic        Write,
    output logic        RYin,
    output logic        RZin,
    output logic        RZLOout,
    output logic        Cout,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        BAout,
    output logic [4:0]  ops,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    state_t     w_end;
    logic [4:0] r_opc;
    logic [4:0] w_opc;
    logic       w_mem_rdy;
    logic       w_unused;

`ifdef CU_MEM_WAIT_EN
    assign w_mem_rdy = mem_rdy;
`else
    assign w_mem_rdy = 1'b1;
`endif

    // Only the opcode field of ir matters here.
    assign w_unused = ^ir[26:0];

    // IR is written at the end of T2, so the opcode is only valid from T3
    // onward: T3 decodes it live, later steps use the latched copy.
    assign w_opc = (r_state == S_T3) ? ir[31:27] : r_opc;
    assign w_end = run ? S_T0 : S_IDLE;

    // Next-state selection; run is only looked at in IDLE and at instruction end.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = run ? S_T0 : S_IDLE;
            S_T0:   w_state_nxt = S_T1;
            S_T1:   w_state_nxt = w_mem_rdy ? S_T2 : S_T1;
            S_T2:   w_state_nxt = S_T3;
            S_T3: begin
                if (w_opc == OPC_LD || w_opc == OPC_LDI || w_opc == OPC_ST ||
                    w_opc == OPC_ADD || w_opc == OPC_SUB || w_opc == OPC_ADDI)
                    w_state_nxt = S_T4;
                else if (w_opc == OPC_HALT)
                    w_state_nxt = S_HALT;
                else
                    w_state_nxt = w_end;
            end
            S_T4:   w_state_nxt = S_T5;
            S_T5:   w_state_nxt = (w_opc == OPC_LD || w_opc == OPC_ST) ? S_T6 : w_end;
            S_T6: begin
                if (w_opc == OPC_LD)
                    w_state_nxt = w_mem_rdy ? S_T7 : S_T6;
                else
                    w_state_nxt = S_T7;
            end
            S_T7: begin
                if (w_opc == OPC_ST)
                    w_state_nxt = w_mem_rdy ? w_end : S_T7;
                else
                    w_state_nxt = w_end;
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and opcode registers; clear aborts any instruction at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_opc   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_T3)
                r_opc <= ir[31:27];
        end
    end

    // Moore output decode from the state and opcode registers.
    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write} = '0;
        {RYin, RZin, RZLOout, Cout, gra, grb, grc, rin, rout, BAout} = '0;
        ops     = 5'd0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_T0: {PCout, MARin, IncPC, RZin} = 4'b1111;
            S_T1: {RZLOout, PCin, Read, MDRin} = 4'b1111;
            S_T2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                if (w_opc == OPC_LD || w_opc == OPC_LDI || w_opc == OPC_ST)
                    {grb, BAout, RYin} = 3'b111;
                else if (w_opc == OPC_ADD || w_opc == OPC_SUB || w_opc == OPC_ADDI)
                    {grb, rout, RYin} = 3'b111;
                else if (w_opc != OPC_NOP && w_opc != OPC_HALT)
                    illegal = 1'b1;
            end
            S_T4: begin
                RZin = 1'b1;
                if (w_opc == OPC_ADD || w_opc == OPC_SUB) begin
                    {grc, rout} = 2'b11;
                    ops = (w_opc == OPC_SUB) ? OP_SUB : OP_ADD;
                end else begin
                    Cout = 1'b1;
                    ops  = OP_ADD;
                end
            end
            S_T5: begin
                RZLOout = 1'b1;
                if (w_opc == OPC_LD || w_opc == OPC_ST)
                    MARin = 1'b1;
                else
                    {gra, rin} = 2'b11;
            end
            S_T6: begin
                MDRin = 1'b1;
                if (w_opc == OPC_LD)
                    Read = 1'b1;
                else
                    {gra, rout} = 2'b11;
            end
            S_T7: begin
                if (w_opc == OPC_LD)
                    {MDRout, gra, rin} = 3'b111;
                else
                    Write = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // Only one source may drive the shared bus in any state.
    a_bus_onehot: assert property (@(posedge clock) disable iff (clear)
        $onehot0({PCout, MDRout, RZLOout, rout, BAout, Cout}));

endmodule
